gold_shift_sequencer: RTL

GOLD_SHIFT_SEQUENCER -- requirements
Module: gold_shift_sequencer

---
 rtl/gold_shift_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/gold_shift_sequencer.sv
// gold_shift_sequencer: emits one AXI-Stream frame of Gold code shift values per period.
//   Optional feature macro: GOLD_SHIFT_OVERRUN_CNT_EN (adds the overrun_cnt output).
//   clkin          : sole clock, rising edge
//   rst            : synchronous active-high reset
//   en             : frame generation enable
//   m_axis_tdata   : shift value (W bits)
//   m_axis_tvalid  : beat valid
//   m_axis_tready  : sink ready
//   m_axis_tlast   : final beat of a frame
//   overrun_cnt    : saturating count of overrun pulses (macro builds only)
//   overrun        : one-cycle pulse when a frame start is dropped
module gold_shift_sequencer #(
    parameter int N          = 63,
    parameter int W          = $clog2(N),
    parameter int NUM_SHIFTS = 11,
    parameter int START      = 0,
    parameter int STEP       = 1,
    parameter int PERIOD     = 100000
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
`ifdef GOLD_SHIFT_OVERRUN_CNT_EN
    output logic [15:0]  overrun_cnt,
`endif
    output logic         overrun
);
    localparam int PW = $clog2(PERIOD);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state;
    logic [PW-1:0] r_pcnt;
    logic [W-1:0]  r_idx;
    logic [W-1:0]  r_value;
    logic [W-1:0]  r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_overrun;
    logic          w_req;
    logic          w_hs;
    logic          w_last;
    logic [W:0]    w_sum;
    logic [W-1:0]  w_next;

    assign w_req  = en && r_pcnt == '0;
    assign w_hs   = r_tvalid && m_axis_tready;
    // one extra bit keeps value+STEP from overflowing before the single mod-N subtraction
    assign w_sum  = {1'b0, r_value} + (W+1)'(STEP);
    assign w_next = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
    assign w_last = (r_idx + W'(1)) == W'(NUM_SHIFTS - 1);

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pcnt    <= '0;
            r_idx     <= '0;
            r_value   <= W'(START);
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pcnt    <= (!en || r_pcnt == PW'(PERIOD - 1)) ? '0 : r_pcnt + PW'(1);
            // a start request that lands while a frame is still in flight is dropped
            r_overrun <= w_req && r_state == SEND;
            if (r_state == IDLE) begin
                if (w_req) begin
                    r_state  <= SEND;
                    r_idx    <= '0;
                    r_value  <= W'(START);
                    r_tdata  <= W'(START);
                    r_tvalid <= 1'b1;
                    r_tlast  <= NUM_SHIFTS == 1;
                end
            end else if (w_hs) begin
                if (r_tlast) begin
                    r_state  <= IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end else begin
                    r_idx    <= r_idx + W'(1);
                    r_value  <= w_next;
                    r_tdata  <= w_next;
                    r_tlast  <= w_last;
                end
            end
        end
    end

`ifdef GOLD_SHIFT_OVERRUN_CNT_EN
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge clkin) begin
        if (rst)
            r_ovr_cnt <= '0;
        else if (r_overrun && r_ovr_cnt != 16'hFFFF)
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end

    assign overrun_cnt = r_ovr_cnt;
`endif

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign overrun       = r_overrun;
endmodule
